ser_port_gen2: RTL



---
 rtl/ser_port_gen2.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ser_port_gen2.sv
// Parametrised serial port: shifts an SB register out on sout and in from sin,
// clocked by an internal divider (slow/fast) or by a synchronised external sck pin.
module ser_port_gen2 #(
  parameter int DATA_W    = 8,
  parameter int HALF_SLOW = 256,
  parameter int HALF_FAST = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              sb_write,
  input  logic [DATA_W-1:0] sb_wdata,
  output logic [DATA_W-1:0] sb_rdata,
  input  logic              sc_write,
  input  logic [7:0]        sc_wdata,
  output logic [7:0]        sc_rdata,
  input  logic              sck_in,
  output logic              sck_out,
  output logic              sck_dir,
  input  logic              sin,
  output logic              sout,
  output logic              int_serial
);

  // state   | meaning
  // ST_IDLE | no transfer; start bit reads 0, serial clock edges ignored
  // ST_BUSY | transfer in progress; start bit reads 1
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam int HALF_MAX = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
  localparam int CNT_W    = $clog2(DATA_W + 1);
  localparam int DIV_W    = $clog2(HALF_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] HALF_S_M1 = DIV_W'(HALF_SLOW - 1);
  localparam logic [DIV_W-1:0] HALF_F_M1 = DIV_W'(HALF_FAST - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sb_q, sb_d;
  logic              lsb_first_q, lsb_first_d;
  logic              fast_q, fast_d;
  logic              int_clk_q, int_clk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sck_out_q, sck_out_d;
  logic              sout_q, sout_d;
  logic              int_serial_q, int_serial_d;
  logic              sck_s1_q, sck_s1_d;
  logic              sck_s2_q, sck_s2_d;
  logic              sck_s3_q, sck_s3_d;
  logic              sin_s1_q, sin_s1_d;
  logic              sin_s2_q, sin_s2_d;

  logic              shift_ev;
  logic              out_ev;
  logic [DIV_W-1:0]  half_m1;
  logic              unused_sc_bits;

  assign unused_sc_bits = ^sc_wdata[6:3];

  always_comb begin
    state_d      = state_q;
    sb_d         = sb_q;
    lsb_first_d  = lsb_first_q;
    fast_d       = fast_q;
    int_clk_d    = int_clk_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    sck_out_d    = sck_out_q;
    sout_d       = sout_q;
    int_serial_d = 1'b0;
    sck_s1_d     = sck_in;
    sck_s2_d     = sck_s1_q;
    sck_s3_d     = sck_s2_q;
    sin_s1_d     = sin;
    sin_s2_d     = sin_s1_q;
    shift_ev     = 1'b0;
    out_ev       = 1'b0;
    half_m1      = fast_q ? HALF_F_M1 : HALF_S_M1;

    if (state_q == ST_BUSY) begin
      if (int_clk_q) begin
        // divider wraps every half period; sck_out phase decides fall vs rise
        if (div_q == half_m1) begin
          div_d = '0;
          if (sck_out_q) begin
            sck_out_d = 1'b0;
            out_ev    = 1'b1;
          end else begin
            sck_out_d = 1'b1;
            shift_ev  = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end else begin
        shift_ev = sck_s2_q & ~sck_s3_q;
        out_ev   = ~sck_s2_q & sck_s3_q;
      end
    end

    if (out_ev) begin
      sout_d = lsb_first_q ? sb_q[0] : sb_q[DATA_W-1];
    end

    if (shift_ev) begin
      sb_d = lsb_first_q ? {sin_s2_q, sb_q[DATA_W-1:1]} : {sb_q[DATA_W-2:0], sin_s2_q};
      if (cnt_q == CNT_LAST) begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        int_serial_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (sb_write) begin
      sb_d = sb_wdata;
    end

    // SC write overrides any same-cycle completion: restart or abort, never an interrupt
    if (sc_write) begin
      state_d      = sc_wdata[7] ? ST_BUSY : ST_IDLE;
      lsb_first_d  = sc_wdata[2];
      fast_d       = sc_wdata[1];
      int_clk_d    = sc_wdata[0];
      cnt_d        = '0;
      div_d        = '0;
      sck_out_d    = 1'b1;
      int_serial_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      sb_q         <= '0;
      lsb_first_q  <= 1'b0;
      fast_q       <= 1'b0;
      int_clk_q    <= 1'b0;
      cnt_q        <= '0;
      div_q        <= '0;
      sck_out_q    <= 1'b1;
      sout_q       <= 1'b1;
      int_serial_q <= 1'b0;
      sck_s1_q     <= 1'b1;
      sck_s2_q     <= 1'b1;
      sck_s3_q     <= 1'b1;
      sin_s1_q     <= 1'b1;
      sin_s2_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      sb_q         <= sb_d;
      lsb_first_q  <= lsb_first_d;
      fast_q       <= fast_d;
      int_clk_q    <= int_clk_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      sck_out_q    <= sck_out_d;
      sout_q       <= sout_d;
      int_serial_q <= int_serial_d;
      sck_s1_q     <= sck_s1_d;
      sck_s2_q     <= sck_s2_d;
      sck_s3_q     <= sck_s3_d;
      sin_s1_q     <= sin_s1_d;
      sin_s2_q     <= sin_s2_d;
    end
  end

  assign sb_rdata   = sb_q;
  assign sc_rdata   = {state_q == ST_BUSY, 4'b1111, lsb_first_q, fast_q, int_clk_q};
  assign sck_out    = sck_out_q;
  assign sck_dir    = int_clk_q;
  assign sout       = sout_q;
  assign int_serial = int_serial_q;

endmodule
